qed_inst_filter: RTL and testbench
==================================

Name: qed_inst_filter

Overview:
- Parametrised, stateful successor to the static SQED instruction constraint. Classifies each fetched instruction into one of 12 classes and checks it against per-commit-phase class masks and original/duplicate register and memory partitions.
- Tracks QED progress with an original/duplicate phase FSM, issue counters and a store-gap timer.
- Emits `inst_legal`, which the formal wrapper binds as the instruction assumption ahead of the picorv32 QED top.

Parameters:
- REG_SPLIT, 16, first register of the duplicate half. Original half is regs 0..REG_SPLIT-1; duplicate half is x0 plus REG_SPLIT..31.
- MEM_SPLIT, 64, unsigned imm12 boundary. Original half is imm < MEM_SPLIT; duplicate half is MEM_SPLIT <= imm < 2*MEM_SPLIT.
- CNT_W, 8, width of the issue counters.
- STORE_GAP, 1, number of cycles after a counted store during which LOAD/STORE are illegal.
- MASK_PRE, 12'hFFF, class-enable mask while `sif_commit`=0.
- MASK_POST, 12'hFFF, class-enable mask while `sif_commit`=1.
- PC_RD0, 1, when 1, JAL/JALR/AUIPC require rd==0 (PC-dependent results).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instruction  in  32  candidate instruction
- instr_valid  in  1  instruction is issued this cycle
- exec_dup  in  1  QED duplicate-mode request
- sif_commit  in  1  commit point reached; selects the mask
- inst_legal  out  1  combinational legality verdict
- inst_class  out  12  one-hot class: {NOP,SYSTEM,FENCE,AUIPC,LUI,JALR,JAL,BRANCH,STORE,LOAD,I,R}, index 0=R
- phase  out  2  FSM state
- orig_count  out  CNT_W  counted originals
- dup_count  out  CNT_W  counted duplicates
- protocol_err  out  1  sticky error flag

Behaviour:
- Decode is combinational. Opcode, funct3 and funct7 rules follow RV32I.
  - NOP = opcode 7'h7F.
  - Unknown encodings give `inst_class`=0 and `inst_legal`=0.
- Register rule:
  - ORIG/IDLE phases: all used rs1/rs2/rd must be < REG_SPLIT.
  - DUP phase: each used register must be 0 or >= REG_SPLIT.
  - Unused register fields are ignored.
- LOAD/STORE rule: rs1==0, and imm12 must lie in the current phase's memory half.
- SYSTEM rule: ECALL or EBREAK only, with rd=rs1=0.
- Verdict: `inst_legal` = decoded class legal AND (class bit & selected mask) AND phase rule AND gap rule.
- Counting: a "counted" issue is `instr_valid` && `inst_legal` && class != NOP.
- States (encoding 0..3): IDLE, ORIG, DUP, DONE.
  - IDLE -> ORIG on a counted issue with `exec_dup`=0. `orig_count` increments.
  - IDLE/ORIG -> DUP on `instr_valid` with `exec_dup`=1 when `orig_count` > 0. If `orig_count`=0, `protocol_err` is set and the FSM stays in place.
  - ORIG: in ORIG, a counted issue increments `orig_count`. When `orig_count` == 2^CNT_W-1, further non-NOP is illegal (no wrap).
  - DUP: non-NOP is legal only if `dup_count` < `orig_count`. A counted issue increments `dup_count`.
  - DUP -> DONE in the cycle after the increment that makes `dup_count` == `orig_count`.
  - DONE: only NOP is legal. The FSM holds until `rst`.
- `exec_dup`=0 with `instr_valid` while in DUP sets `protocol_err` (sticky until `rst`).
- Store gap:
  - A counted STORE loads `gap_cnt`=STORE_GAP.
  - `gap_cnt` != 0 makes LOAD/STORE illegal.
  - `gap_cnt` decrements each cycle, saturating at 0.
  - STORE_GAP=0 disables the gap.
- Reset (synchronous): `phase`=IDLE, counters=0, `gap_cnt`=0, `protocol_err`=0, registered outputs 0. `inst_legal` and `inst_class` still evaluate from the current inputs. A reset mid-DUP abandons the run with no residue.
- Latency: the verdict is same-cycle. State updates become visible the next cycle.
- `instr_valid`=0: no state change except `gap_cnt` decrement.

Decomposition:
- Package `qed_filter_pkg` holds:
  - the class index localparams (CLS_R..CLS_NOP, NUM_CLS=12);
  - the phase enum `qed_phase_e`;
  - the RV32I opcode/funct3/funct7 constants.
- Sub-module `qed_inst_classify`: a pure combinational decoder. It takes `instruction` and outputs the class one-hot plus per-field use flags (`uses_rs1`, `uses_rs2`, `uses_rd`) and imm12.
- Top level holds the partition checks, FSM, counters and gap timer.

Test Plan:
- Reset, then ADD x3,x1,x2 with valid → `inst_legal`=1; next cycle `phase`=ORIG, `orig_count`=1.
- After 3 originals, `exec_dup`=1 with ADD x19,x17,x18 ×3 → `dup_count` 1,2,3. After the 3rd, `phase`=DONE; then ADDI → `inst_legal`=0 and NOP → 1.
- In DUP with `dup_count`==`orig_count`-1, ADD x3,x1,x2 (original registers) → `inst_legal`=0 and the counters are unchanged.
- SW x1,0(x0) counted, then LW x2,4(x0) next cycle → illegal (STORE_GAP=1). The same LW one cycle later → legal.
- `sif_commit`=0 with MASK_PRE=12'h800 → ADD illegal and NOP legal. Raise `sif_commit` with MASK_POST=12'hFFF → ADD legal.
- Valid `exec_dup`=1 in IDLE → `protocol_err`=1 and `phase` stays IDLE. Then `rst` → `protocol_err`=0.

Source files
------------

// File: rtl/qed_filter_pkg.sv
// qed_filter_pkg
//   Shared definitions for the QED instruction filter: one-hot class
//   indices, the QED phase encoding and the RV32I opcode/funct fields
//   the classifier and the filter both need.
package qed_filter_pkg;

  // One-hot class bit positions; bit 0 is R-type, bit 11 is the custom NOP
  localparam int NUM_CLS    = 12;
  localparam int CLS_R      = 0;
  localparam int CLS_I      = 1;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_JAL    = 5;
  localparam int CLS_JALR   = 6;
  localparam int CLS_LUI    = 7;
  localparam int CLS_AUIPC  = 8;
  localparam int CLS_FENCE  = 9;
  localparam int CLS_SYSTEM = 10;
  localparam int CLS_NOP    = 11;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_ORIG = 2'd1,
    PH_DUP  = 2'd2,
    PH_DONE = 2'd3
  } qed_phase_e;

  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_NOP    = 7'h7F;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_ZERO    = 3'b000;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [11:0] IMM_ECALL  = 12'h000;
  localparam logic [11:0] IMM_EBREAK = 12'h001;

endpackage

// File: rtl/qed_inst_classify.sv
// qed_inst_classify
//   Pure combinational RV32I decoder. Produces a one-hot class (all zero
//   for encodings that are not valid RV32I or the custom NOP), flags for
//   which register fields the instruction actually reads/writes, and the
//   12-bit immediate in the position loads/stores use.
// Ports:
//   instruction  in   32       candidate instruction word
//   inst_class   out  NUM_CLS  one-hot class, zero when unknown
//   uses_rs1     out  1        rs1 field is a real source
//   uses_rs2     out  1        rs2 field is a real source
//   uses_rd      out  1        rd field is a real destination
//   imm12        out  12       S-format imm for stores, I-format otherwise
module qed_inst_classify
  import qed_filter_pkg::*;
(
  input  logic [31:0]        instruction,
  output logic [NUM_CLS-1:0] inst_class,
  output logic               uses_rs1,
  output logic               uses_rs2,
  output logic               uses_rd,
  output logic [11:0]        imm12
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  // Decode by opcode, then qualify with funct3/funct7 so reserved
  // encodings fall through with an all-zero class.
  always_comb begin
    inst_class = '0;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    uses_rd    = 1'b0;
    imm12      = instruction[31:20];
    case (opcode)
      OP_OP: begin
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SR))) begin
          inst_class[CLS_R] = 1'b1;
          uses_rs1          = 1'b1;
          uses_rs2          = 1'b1;
          uses_rd           = 1'b1;
        end
      end
      OP_IMM: begin
        // Shift-immediates reuse funct7 as an encoding field
        if ((funct3 == F3_SLL) ? (funct7 == F7_BASE) :
            (funct3 == F3_SR)  ? (funct7 == F7_BASE || funct7 == F7_ALT) : 1'b1) begin
          inst_class[CLS_I] = 1'b1;
          uses_rs1          = 1'b1;
          uses_rd           = 1'b1;
        end
      end
      OP_LOAD: begin
        if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
          inst_class[CLS_LOAD] = 1'b1;
          uses_rs1             = 1'b1;
          uses_rd              = 1'b1;
        end
      end
      OP_STORE: begin
        imm12 = {instruction[31:25], instruction[11:7]};
        if (funct3 <= 3'b010) begin
          inst_class[CLS_STORE] = 1'b1;
          uses_rs1              = 1'b1;
          uses_rs2              = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          inst_class[CLS_BRANCH] = 1'b1;
          uses_rs1               = 1'b1;
          uses_rs2               = 1'b1;
        end
      end
      OP_JAL: begin
        inst_class[CLS_JAL] = 1'b1;
        uses_rd             = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == F3_ZERO) begin
          inst_class[CLS_JALR] = 1'b1;
          uses_rs1             = 1'b1;
          uses_rd              = 1'b1;
        end
      end
      OP_LUI: begin
        inst_class[CLS_LUI] = 1'b1;
        uses_rd             = 1'b1;
      end
      OP_AUIPC: begin
        inst_class[CLS_AUIPC] = 1'b1;
        uses_rd               = 1'b1;
      end
      OP_FENCE: begin
        if (funct3 == F3_ZERO) inst_class[CLS_FENCE] = 1'b1;
      end
      OP_SYSTEM: begin
        // Only the privileged funct3=0 group; ECALL/EBREAK are picked out by the filter
        if (funct3 == F3_ZERO) inst_class[CLS_SYSTEM] = 1'b1;
      end
      OP_NOP: begin
        inst_class[CLS_NOP] = 1'b1;
      end
      default: begin
        inst_class = '0;
      end
    endcase
  end

endmodule

// File: rtl/qed_inst_filter.sv
// qed_inst_filter
//   Stateful QED instruction constraint. Classifies the candidate
//   instruction, checks it against the commit-phase class mask and the
//   original/duplicate register and memory partitions, and tracks QED
//   progress (phase FSM, issue counters, store-gap timer).
// Ports:
//   clk           in   1        clock
//   rst           in   1        synchronous active-high reset
//   instruction   in   32       candidate instruction
//   instr_valid   in   1        instruction is issued this cycle
//   exec_dup      in   1        duplicate-mode request
//   sif_commit    in   1        commit point reached, selects MASK_POST
//   inst_legal    out  1        combinational legality verdict
//   inst_class    out  12       one-hot class of the instruction
//   phase         out  2        QED phase (IDLE/ORIG/DUP/DONE)
//   orig_count    out  CNT_W    counted originals
//   dup_count     out  CNT_W    counted duplicates
//   protocol_err  out  1        sticky protocol error
module qed_inst_filter
  import qed_filter_pkg::*;
#(
  parameter int          REG_SPLIT = 16,
  parameter int          MEM_SPLIT = 64,
  parameter int          CNT_W     = 8,
  parameter int          STORE_GAP = 1,
  parameter logic [11:0] MASK_PRE  = 12'hFFF,
  parameter logic [11:0] MASK_POST = 12'hFFF,
  parameter bit          PC_RD0    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instruction,
  input  logic               instr_valid,
  input  logic               exec_dup,
  input  logic               sif_commit,
  output logic               inst_legal,
  output logic [NUM_CLS-1:0] inst_class,
  output logic [1:0]         phase,
  output logic [CNT_W-1:0]   orig_count,
  output logic [CNT_W-1:0]   dup_count,
  output logic               protocol_err
);

  localparam int               GAP_W     = (STORE_GAP > 1) ? $clog2(STORE_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(STORE_GAP);
  localparam logic [5:0]       REG_SPL_V = 6'(REG_SPLIT);
  localparam logic [12:0]      MEM_LO_V  = 13'(MEM_SPLIT);
  localparam logic [12:0]      MEM_HI_V  = 13'(2 * MEM_SPLIT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  qed_phase_e         state_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic [NUM_CLS-1:0] cls;
  logic               uses_rs1, uses_rs2, uses_rd;
  logic [11:0]        imm12;
  logic [4:0]         rd, rs1, rs2;
  logic               eff_dup, is_nop, is_ldst;
  logic               class_ok, mask_ok, reg_ok, mem_ok, phase_ok, gap_ok;
  logic               counted;

  qed_inst_classify u_classify (
    .instruction (instruction),
    .inst_class  (cls),
    .uses_rs1    (uses_rs1),
    .uses_rs2    (uses_rs2),
    .uses_rd     (uses_rd),
    .imm12       (imm12)
  );

  assign rd         = instruction[11:7];
  assign rs1        = instruction[19:15];
  assign rs2        = instruction[24:20];
  assign inst_class = cls;
  assign is_nop     = cls[CLS_NOP];
  assign is_ldst    = cls[CLS_LOAD] | cls[CLS_STORE];

  // The instruction that carries the ORIG->DUP switch is itself the first
  // duplicate, so it is judged against the duplicate partition.
  assign eff_dup = (state_q == PH_DUP) || (state_q == PH_ORIG && exec_dup);

  // x0 is shared by both halves; the duplicate half is REG_SPLIT..31
  function automatic logic reg_in_half(input logic [4:0] r, input logic dup);
    if (dup) return (r == 5'd0) || ({1'b0, r} >= REG_SPL_V);
    return {1'b0, r} < REG_SPL_V;
  endfunction

  // Per-class encoding restrictions beyond plain RV32I decode
  always_comb begin
    class_ok = 1'b1;
    if (cls[CLS_SYSTEM])
      class_ok = (imm12 == IMM_ECALL || imm12 == IMM_EBREAK) && rd == 5'd0 && rs1 == 5'd0;
    if (PC_RD0 && (cls[CLS_JAL] || cls[CLS_JALR] || cls[CLS_AUIPC]))
      class_ok = (rd == 5'd0);
  end

  // Unknown encodings have an all-zero class and therefore fail here
  assign mask_ok = |(cls & (sif_commit ? MASK_POST : MASK_PRE));

  assign reg_ok = (!uses_rd  || reg_in_half(rd,  eff_dup)) &&
                  (!uses_rs1 || reg_in_half(rs1, eff_dup)) &&
                  (!uses_rs2 || reg_in_half(rs2, eff_dup));

  // Memory accesses are absolute (base x0) into the phase's imm12 window
  always_comb begin
    mem_ok = 1'b1;
    if (is_ldst) begin
      if (eff_dup)
        mem_ok = (rs1 == 5'd0) && ({1'b0, imm12} >= MEM_LO_V) && ({1'b0, imm12} < MEM_HI_V);
      else
        mem_ok = (rs1 == 5'd0) && ({1'b0, imm12} < MEM_LO_V);
    end
  end

  // Progress limits: no wrap of orig_count, no more duplicates than
  // originals, nothing but NOP once the run is complete.
  always_comb begin
    phase_ok = 1'b1;
    if (!is_nop) begin
      if (state_q == PH_DONE)      phase_ok = 1'b0;
      else if (eff_dup)            phase_ok = dup_count < orig_count;
      else if (state_q == PH_ORIG) phase_ok = orig_count != CNT_MAX;
    end
  end

  assign gap_ok     = !(is_ldst && gap_cnt != '0);
  assign inst_legal = class_ok && mask_ok && reg_ok && mem_ok && phase_ok && gap_ok;
  assign counted    = instr_valid && inst_legal && !is_nop;

  // Phase FSM, issue counters, store-gap timer and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PH_IDLE;
      orig_count   <= '0;
      dup_count    <= '0;
      gap_cnt      <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (counted && cls[CLS_STORE])
        gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;

      case (state_q)
        PH_IDLE, PH_ORIG: begin
          if (instr_valid && exec_dup) begin
            if (orig_count != '0) begin
              state_q <= PH_DUP;
              if (counted) begin
                dup_count <= dup_count + 1'b1;
                if ((dup_count + 1'b1) == orig_count) state_q <= PH_DONE;
              end
            end else begin
              protocol_err <= 1'b1;
            end
          end else if (counted) begin
            state_q    <= PH_ORIG;
            orig_count <= orig_count + 1'b1;
          end
        end
        PH_DUP: begin
          if (instr_valid && !exec_dup) protocol_err <= 1'b1;
          if (counted) begin
            dup_count <= dup_count + 1'b1;
            if ((dup_count + 1'b1) == orig_count) state_q <= PH_DONE;
          end
        end
        default: begin
          state_q <= PH_DONE;
        end
      endcase
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_qed_inst_filter.sv
// tb_qed_inst_filter
//   Scoreboard bench for qed_inst_filter. Each driven cycle pushes the
//   reference model's expected verdict/class and the expected visible state
//   into a queue; a monitor on the falling edge pops and compares. A few
//   directed scenarios add fixed-value checks.
module tb_qed_inst_filter;

  localparam int          TB_CW     = 4;
  localparam int          RSPLIT    = 16;
  localparam int          MSPLIT    = 64;
  localparam int          GAP       = 1;
  localparam logic [11:0] M_PRE     = 12'h800;
  localparam logic [11:0] M_POST    = 12'hFFF;
  localparam int          CMAX      = (1 << TB_CW) - 1;
  localparam logic [31:0] NOP_W     = 32'h0000007F;

  localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4, C_JAL = 5;
  localparam int C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_FENCE = 9, C_SYSTEM = 10, C_NOP = 11;

  logic              clk;
  logic              rst;
  logic [31:0]       instruction;
  logic              instr_valid;
  logic              exec_dup;
  logic              sif_commit;
  logic              inst_legal;
  logic [11:0]       inst_class;
  logic [1:0]        phase;
  logic [TB_CW-1:0]  orig_count;
  logic [TB_CW-1:0]  dup_count;
  logic              protocol_err;

  qed_inst_filter #(
    .REG_SPLIT (RSPLIT),
    .MEM_SPLIT (MSPLIT),
    .CNT_W     (TB_CW),
    .STORE_GAP (GAP),
    .MASK_PRE  (M_PRE),
    .MASK_POST (M_POST),
    .PC_RD0    (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .exec_dup     (exec_dup),
    .sif_commit   (sif_commit),
    .inst_legal   (inst_legal),
    .inst_class   (inst_class),
    .phase        (phase),
    .orig_count   (orig_count),
    .dup_count    (dup_count),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        legal;
    logic [11:0] cls;
    logic [1:0]  ph;
    logic [7:0]  oc;
    logic [7:0]  dc;
    logic        perr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: the QED run as abstract counts
  int m_phase, m_orig, m_dup, m_gap;
  bit m_perr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  function automatic logic [31:0] encR(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] encI(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] encS(int imm, int rs2, int rs1, int f3, logic [6:0] op);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], op};
  endfunction

  function automatic bit inHalf(int r, bit dup);
    if (dup) return (r == 0) || (r >= RSPLIT);
    return r < RSPLIT;
  endfunction

  // RV32I field rules written out directly; returns -1 for an unknown encoding
  function automatic int modelDecode(input logic [31:0] ins, output bit ur1, output bit ur2,
                                     output bit urd, output int imm);
    int op, f3, f7;
    op  = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    ur1 = 0; ur2 = 0; urd = 0;
    imm = int'(ins[31:20]);
    case (op)
      'h33: begin ur1 = 1; ur2 = 1; urd = 1;
        if (f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5))) return C_R; end
      'h13: begin ur1 = 1; urd = 1;
        if (f3 == 1) begin if (f7 == 0) return C_I; end
        else if (f3 == 5) begin if (f7 == 0 || f7 == 'h20) return C_I; end
        else return C_I; end
      'h03: begin ur1 = 1; urd = 1; if (f3 inside {0, 1, 2, 4, 5}) return C_LOAD; end
      'h23: begin ur1 = 1; ur2 = 1; imm = int'({ins[31:25], ins[11:7]});
        if (f3 <= 2) return C_STORE; end
      'h63: begin ur1 = 1; ur2 = 1; if (f3 != 2 && f3 != 3) return C_BRANCH; end
      'h6F: begin urd = 1; return C_JAL; end
      'h67: begin ur1 = 1; urd = 1; if (f3 == 0) return C_JALR; end
      'h37: begin urd = 1; return C_LUI; end
      'h17: begin urd = 1; return C_AUIPC; end
      'h0F: if (f3 == 0) return C_FENCE;
      'h73: if (f3 == 0) return C_SYSTEM;
      'h7F: return C_NOP;
      default: ;
    endcase
    ur1 = 0; ur2 = 0; urd = 0;
    return -1;
  endfunction

  task automatic modelEval(input logic [31:0] ins, input bit ed, input bit sc,
                           output bit legal, output int c);
    int rd, rs1, rs2, imm, ph;
    bit ur1, ur2, urd, ok;
    logic [11:0] mask;
    c     = modelDecode(ins, ur1, ur2, urd, imm);
    rd    = int'(ins[11:7]);
    rs1   = int'(ins[19:15]);
    rs2   = int'(ins[24:20]);
    legal = 0;
    if (c < 0) return;
    ok   = 1;
    mask = sc ? M_POST : M_PRE;
    if (!mask[c]) ok = 0;
    if (c == C_SYSTEM && !((imm == 0 || imm == 1) && rd == 0 && rs1 == 0)) ok = 0;
    if ((c == C_JAL || c == C_JALR || c == C_AUIPC) && rd != 0) ok = 0;
    ph = (m_phase == 1 && ed) ? 2 : m_phase;
    if (urd && !inHalf(rd, ph == 2)) ok = 0;
    if (ur1 && !inHalf(rs1, ph == 2)) ok = 0;
    if (ur2 && !inHalf(rs2, ph == 2)) ok = 0;
    if (c == C_LOAD || c == C_STORE) begin
      if (rs1 != 0) ok = 0;
      if (ph == 2) begin
        if (imm < MSPLIT || imm >= 2 * MSPLIT) ok = 0;
      end else if (imm >= MSPLIT) ok = 0;
      if (m_gap > 0) ok = 0;
    end
    if (c != C_NOP) begin
      if (m_phase == 3) ok = 0;
      else if (ph == 2 && m_dup >= m_orig) ok = 0;
      else if (ph == 1 && m_orig == CMAX) ok = 0;
    end
    legal = ok;
  endtask

  task automatic modelReset();
    m_phase = 0; m_orig = 0; m_dup = 0; m_gap = 0; m_perr = 0;
  endtask

  task automatic modelStep(input bit r, input bit v, input bit ed, input bit legal, input int c);
    bit counted;
    if (r) begin modelReset(); return; end
    counted = v && legal && c != C_NOP;
    if (counted && c == C_STORE) m_gap = GAP;
    else if (m_gap > 0) m_gap--;
    if (m_phase == 0 || m_phase == 1) begin
      if (v && ed) begin
        if (m_orig > 0) begin
          m_phase = 2;
          if (counted) begin m_dup++; if (m_dup == m_orig) m_phase = 3; end
        end else m_perr = 1;
      end else if (counted) begin
        m_phase = 1; m_orig++;
      end
    end else if (m_phase == 2) begin
      if (v && !ed) m_perr = 1;
      if (counted) begin m_dup++; if (m_dup == m_orig) m_phase = 3; end
    end
  endtask

  // Drive one cycle just after the rising edge and queue what the DUT must show
  task automatic applyStimulus(input bit r, input bit v, input bit ed, input bit sc,
                               input logic [31:0] ins);
    exp_t e;
    bit   legal;
    int   c;
    @(posedge clk);
    #1;
    rst = r; instr_valid = v; exec_dup = ed; sif_commit = sc; instruction = ins;
    modelEval(ins, ed, sc, legal, c);
    e.legal = legal;
    e.cls   = (c < 0) ? 12'h000 : 12'(1 << c);
    e.ph    = 2'(m_phase);
    e.oc    = 8'(m_orig);
    e.dc    = 8'(m_dup);
    e.perr  = m_perr;
    exp_q.push_back(e);
    modelStep(r, v, ed, legal, c);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("inst_legal",   32'(inst_legal),   32'(e.legal));
      checkOutput("inst_class",   32'(inst_class),   32'(e.cls));
      checkOutput("phase",        32'(phase),        32'(e.ph));
      checkOutput("orig_count",   32'(orig_count),   32'(e.oc));
      checkOutput("dup_count",    32'(dup_count),    32'(e.dc));
      checkOutput("protocol_err", 32'(protocol_err), 32'(e.perr));
    end
  end

  function automatic int regPick(bit dup);
    if ($urandom_range(0, 7) == 0) return $urandom_range(0, 31);
    if (dup) return ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(RSPLIT, 31);
    return $urandom_range(0, RSPLIT - 1);
  endfunction

  function automatic int memImm(bit dup);
    if ($urandom_range(0, 7) == 0) return $urandom_range(0, 4095);
    return dup ? $urandom_range(MSPLIT, 2 * MSPLIT - 1) : $urandom_range(0, MSPLIT - 1);
  endfunction

  function automatic logic [31:0] genInstr(bit dup);
    int f7, base;
    base = ($urandom_range(0, 7) == 0) ? regPick(dup) : 0;
    case ($urandom_range(0, 12))
      0: begin
        f7 = ($urandom_range(0, 3) == 0) ? 'h20 : 0;
        if ($urandom_range(0, 9) == 0) f7 = $urandom_range(0, 127);
        return encR(f7, regPick(dup), regPick(dup), $urandom_range(0, 7), regPick(dup));
      end
      1:  return encI($urandom_range(0, 4095), regPick(dup), $urandom_range(0, 7), regPick(dup), 7'h13);
      2:  return encI(memImm(dup), base, $urandom_range(0, 7), regPick(dup), 7'h03);
      3:  return encS(memImm(dup), regPick(dup), base, $urandom_range(0, 3), 7'h23);
      4:  return encS($urandom_range(0, 4095), regPick(dup), regPick(dup), $urandom_range(0, 7), 7'h63);
      5:  return {20'($urandom()), 5'($urandom_range(0, 1) ? 0 : regPick(dup)), 7'h6F};
      6:  return encI($urandom_range(0, 4095), regPick(dup), $urandom_range(0, 1), $urandom_range(0, 1) ? 0 : regPick(dup), 7'h67);
      7:  return {20'($urandom()), 5'(regPick(dup)), 7'h37};
      8:  return {20'($urandom()), 5'($urandom_range(0, 1) ? 0 : regPick(dup)), 7'h17};
      9:  return 32'h0FF0000F;
      10: case ($urandom_range(0, 3))
            0: return 32'h00000073;
            1: return 32'h00100073;
            2: return 32'h30200073;
            default: return 32'h000000F3;
          endcase
      11: return {25'($urandom()), 7'h7F};
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    logic [31:0] add_orig, add_dup, addi_w, sw_w, lw_w;
    bit v, ed, sc;
    add_orig = encR(0, 2, 1, 0, 3);
    add_dup  = encR(0, 18, 17, 0, 19);
    addi_w   = encI(1, 0, 0, 1, 7'h13);
    sw_w     = encS(0, 1, 0, 2, 7'h23);
    lw_w     = encI(4, 0, 2, 2, 7'h03);

    rst = 1'b1; instr_valid = 1'b0; exec_dup = 1'b0; sif_commit = 1'b1; instruction = NOP_W;
    repeat (2) @(posedge clk);
    modelReset();

    $display("[TB] directed scenarios");
    applyStimulus(0, 1, 0, 0, add_orig); @(negedge clk);
    checkOutput("pre_mask_add", 32'(inst_legal), 32'd0);
    applyStimulus(0, 1, 0, 0, NOP_W);    @(negedge clk);
    checkOutput("pre_mask_nop", 32'(inst_legal), 32'd1);
    applyStimulus(0, 1, 0, 1, add_orig); @(negedge clk);
    checkOutput("post_mask_add", 32'(inst_legal), 32'd1);
    applyStimulus(0, 0, 0, 1, NOP_W);    @(negedge clk);
    checkOutput("first_orig_phase", 32'(phase), 32'd1);
    checkOutput("first_orig_count", 32'(orig_count), 32'd1);
    applyStimulus(0, 1, 0, 1, encR(0, 2, 1, 0, 4));
    applyStimulus(0, 1, 0, 1, encR(0, 2, 1, 0, 5));
    applyStimulus(0, 1, 1, 1, add_dup);
    applyStimulus(0, 1, 1, 1, add_dup);  @(negedge clk);
    checkOutput("dup1_phase", 32'(phase), 32'd2);
    checkOutput("dup1_count", 32'(dup_count), 32'd1);
    applyStimulus(0, 1, 1, 1, add_orig); @(negedge clk);
    checkOutput("dup2_count", 32'(dup_count), 32'd2);
    checkOutput("dup_orig_regs", 32'(inst_legal), 32'd0);
    applyStimulus(0, 0, 1, 1, NOP_W);    @(negedge clk);
    checkOutput("dup_hold_count", 32'(dup_count), 32'd2);
    checkOutput("orig_hold_count", 32'(orig_count), 32'd3);
    applyStimulus(0, 1, 1, 1, add_dup);
    applyStimulus(0, 1, 1, 1, addi_w);   @(negedge clk);
    checkOutput("done_phase", 32'(phase), 32'd3);
    checkOutput("done_dup_count", 32'(dup_count), 32'd3);
    checkOutput("done_addi", 32'(inst_legal), 32'd0);
    applyStimulus(0, 1, 1, 1, NOP_W);    @(negedge clk);
    checkOutput("done_nop", 32'(inst_legal), 32'd1);

    applyStimulus(1, 0, 0, 1, NOP_W);
    applyStimulus(0, 1, 0, 1, sw_w);     @(negedge clk);
    checkOutput("sw_legal", 32'(inst_legal), 32'd1);
    applyStimulus(0, 1, 0, 1, lw_w);     @(negedge clk);
    checkOutput("lw_in_gap", 32'(inst_legal), 32'd0);
    applyStimulus(0, 1, 0, 1, lw_w);     @(negedge clk);
    checkOutput("lw_after_gap", 32'(inst_legal), 32'd1);

    applyStimulus(1, 0, 0, 1, NOP_W);
    applyStimulus(0, 1, 1, 1, NOP_W);
    applyStimulus(0, 0, 0, 1, NOP_W);    @(negedge clk);
    checkOutput("idle_dup_err", 32'(protocol_err), 32'd1);
    checkOutput("idle_dup_phase", 32'(phase), 32'd0);
    applyStimulus(1, 0, 0, 1, NOP_W);
    applyStimulus(0, 0, 0, 1, NOP_W);    @(negedge clk);
    checkOutput("err_cleared", 32'(protocol_err), 32'd0);

    $display("[TB] randomized QED runs");
    for (int ep = 0; ep < 40; ep++) begin
      applyStimulus(1, 0, 0, 1, NOP_W);
      for (int i = 0; i < $urandom_range(1, 40); i++) begin
        v  = $urandom_range(0, 9) < 8;
        ed = $urandom_range(0, 29) == 0;
        sc = $urandom_range(0, 9) != 0;
        applyStimulus(0, v, ed, sc, genInstr(1'b0));
      end
      for (int i = 0; i < 60; i++) begin
        v  = $urandom_range(0, 9) < 8;
        ed = $urandom_range(0, 29) != 0;
        sc = $urandom_range(0, 9) != 0;
        applyStimulus(0, v, ed, sc, genInstr(1'b1));
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
